// File: rtl/cp0_regfile.sv
// MIPS coprocessor-0 register file: exception commit, MTC0/MFC0, Count/Compare timer.
// Optional feature: define CP0_TIMER_INT_EN to raise timer_int_o on a Count/Compare match.
module cp0_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [31:0] EXC_ERET     = 32'h0000_000E;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        tick;

    logic        exc_take;
    logic        eret;
    logic [4:0]  exc_code;
    logic        exc_badaddr;

    assign exc_take    = (excepttype_i != 32'd0) && (excepttype_i != EXC_ERET);
    assign eret        = (excepttype_i == EXC_ERET);
    assign exc_code    = (excepttype_i == 32'h0000_0001) ? 5'd0 : excepttype_i[4:0];
    assign exc_badaddr = (excepttype_i == 32'h0000_0004) || (excepttype_i == 32'h0000_0005);

`ifdef CP0_TIMER_INT_EN
    logic timer_int;
    assign timer_int_o = timer_int;
`else
    assign timer_int_o = 1'b0;
`endif

    // NOTE: non-blocking assignments throughout; where two assignments hit the
    // same bits in one edge the later one wins, which gives MTC0 Count/Compare
    // writes priority over the increment and the timer match.
    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr <= 32'd0;
            count    <= 32'd0;
            compare  <= 32'd0;
            status   <= STATUS_RESET;
            cause    <= 32'd0;
            epc      <= 32'd0;
            tick     <= 1'b0;
`ifdef CP0_TIMER_INT_EN
            timer_int <= 1'b0;
`endif
        end else begin
            tick <= ~tick;
            if (tick) begin
                count <= count + 32'd1;
            end

`ifdef CP0_TIMER_INT_EN
            if ((compare != 32'd0) && (count == compare)) begin
                timer_int <= 1'b1;
            end
            cause[15] <= int_i[5] | timer_int;
`else
            cause[15] <= int_i[5];
`endif
            cause[14:10] <= int_i[4:0];

            // The MTC0 writer sits behind the faulting instruction and is flushed.
            if (exc_take) begin
                if (!status[1]) begin
                    epc       <= is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                                   : current_inst_addr_i;
                    cause[31] <= is_in_delayslot_i;
                end
                status[1]  <= 1'b1;
                cause[6:2] <= exc_code;
                if (exc_badaddr) begin
                    badvaddr <= bad_addr_i;
                end
            end else if (eret) begin
                status[1] <= 1'b0;
            end else if (we_i) begin
                case (waddr_i)
                    REG_COUNT:   count <= data_i;
                    REG_COMPARE: begin
                        compare <= data_i;
`ifdef CP0_TIMER_INT_EN
                        timer_int <= 1'b0;
`endif
                    end
                    REG_STATUS:  status <= {9'd0, 1'b1, 6'd0, data_i[15:8], 6'd0, data_i[1:0]};
                    REG_CAUSE:   cause[9:8] <= data_i[9:8];
                    REG_EPC:     epc <= data_i;
                    default:     ;
                endcase
            end
        end
    end

    // NOTE: the default arm assigns data_o on every path, so no latch is inferred.
    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            REG_BADVADDR: data_o = badvaddr;
            REG_COUNT:    data_o = count;
            REG_COMPARE:  data_o = compare;
            REG_STATUS:   data_o = status;
            REG_CAUSE:    data_o = cause;
            REG_EPC:      data_o = epc;
            default:      data_o = 32'd0;
        endcase
    end

    assign status_o   = status;
    assign cause_o    = cause;
    assign epc_o      = epc;
    assign count_o    = count;
    assign compare_o  = compare;
    assign badvaddr_o = badvaddr;

endmodule
